// File: rtl/de4_qsys_test_button_pio.sv
// de4_qsys_test_button_pio: Avalon-MM input PIO with synchroniser, edge capture and maskable irq.
// Define DE4_BUTTON_PIO_DEBOUNCE_EN to add per-bit debounce counters.
module de4_qsys_test_button_pio #(
  parameter int WIDTH = 4,
  parameter int EDGE_TYPE = 1,
  parameter logic [WIDTH-1:0] IN_RESET_VALUE = {WIDTH{1'b1}},
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);
  logic [WIDTH-1:0] sync1_q, sync2_q, data_q, data_d, prev_q, mask_q, mask_d, cap_q, cap_d, edg;
  logic wr, unused_w;
  assign wr = chipselect && !write_n;
  assign unused_w = ^writedata ^ (DEBOUNCE_CYCLES < 1);
  assign edg = EDGE_TYPE == 0 ? data_q & ~prev_q :
               EDGE_TYPE == 1 ? ~data_q & prev_q : data_q ^ prev_q;
  // Set wins over a same-cycle write-1-to-clear.
  assign cap_d = (cap_q & ~((wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0)) | edg;
  assign mask_d = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  assign irq = |(cap_q & mask_q);
  assign readdata = address == 2'd0 ? 32'(data_q) :
                    address == 2'd2 ? 32'(mask_q) :
                    address == 2'd3 ? 32'(cap_q) : '0;
`ifdef DE4_BUTTON_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  always_comb begin
    data_d = data_q;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++)
      if (sync2_q[i] != data_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) data_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign data_d = sync2_q;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1_q <= IN_RESET_VALUE;
      sync2_q <= IN_RESET_VALUE;
      data_q  <= IN_RESET_VALUE;
      prev_q  <= IN_RESET_VALUE;
      mask_q  <= '0;
      cap_q   <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      data_q  <= data_d;
      prev_q  <= data_q;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
    end
endmodule

// File: tb/tb_de4_qsys_test_button_pio.sv
// tb_de4_qsys_test_button_pio: table-driven and sequence checks of the button PIO, falling-edge and any-edge instances.
module tb_de4_qsys_test_button_pio;
  localparam int DC = 8;
`ifdef DE4_BUTTON_PIO_DEBOUNCE_EN
  localparam int DL = DC + 2;
  localparam int RST_AT = 7;
`else
  localparam int DL = 3;
  localparam int RST_AT = 2;
`endif
  logic clk = 0, reset = 0, chipselect = 0, write_n = 1;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0, rd1, rd2;
  logic irq1, irq2;
  logic [3:0] in_port = 4'hF;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  de4_qsys_test_button_pio #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DC)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .irq(irq1), .in_port(in_port));
  de4_qsys_test_button_pio #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DC)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .irq(irq2), .in_port(in_port));
  typedef struct {string name; bit second; int kind; logic [31:0] exp;} item_t;
  typedef struct {logic [3:0] in; logic [3:0] data; logic [3:0] cap1; logic [3:0] cap2; bit irq1; bit irq2;} vec_t;
  item_t sb[$];
  vec_t tbl[5];
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_v(input string name, input bit second, input int kind, input logic [31:0] exp);
    sb.push_back('{name, second, kind, exp});
  endtask
  task automatic check();
    item_t it;
    logic [31:0] act;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      if (it.kind < 4) begin
        address = 2'(it.kind);
        #1;
        act = it.second ? rd2 : rd1;
      end else act = 32'(it.second ? irq2 : irq1);
      checks++;
      if (act !== it.exp) begin
        fails++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
      end
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1;
    write_n = 0;
    tick();
    chipselect = 0;
    write_n = 1;
  endtask
  initial begin
    tbl[0] = '{4'hA, 4'hA, 4'h5, 4'h5, 1'b1, 1'b1};
    tbl[1] = '{4'h5, 4'h5, 4'hA, 4'hF, 1'b1, 1'b1};
    tbl[2] = '{4'h5, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[3] = '{4'h0, 4'h0, 4'h5, 4'h5, 1'b1, 1'b1};
    tbl[4] = '{4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1};
    #3 reset = 1;
    tick(2);
    reset = 0;
    expect_v("rst_data", 0, 0, 32'hF);
    expect_v("rst_addr1", 0, 1, 0);
    expect_v("rst_mask", 0, 2, 0);
    expect_v("rst_cap", 0, 3, 0);
    expect_v("rst_irq1", 0, 4, 0);
    expect_v("rst_irq2", 1, 4, 0);
    check();
    wr(2, 32'hF);
    expect_v("mask_rd", 0, 2, 32'hF);
    check();
    for (int i = 0; i < 5; i++) begin
      wr(3, 32'hF);
      in_port = tbl[i].in;
      tick(DL + 2);
      expect_v($sformatf("tbl%0d_data", i), 0, 0, 32'(tbl[i].data));
      expect_v($sformatf("tbl%0d_cap1", i), 0, 3, 32'(tbl[i].cap1));
      expect_v($sformatf("tbl%0d_cap2", i), 1, 3, 32'(tbl[i].cap2));
      expect_v($sformatf("tbl%0d_irq1", i), 0, 4, 32'(tbl[i].irq1));
      expect_v($sformatf("tbl%0d_irq2", i), 1, 4, 32'(tbl[i].irq2));
      check();
    end
    wr(3, 32'hF);
    wr(2, 0);
    in_port = 4'hE;
    tick(DL - 1);
    expect_v("fall_data_early", 0, 0, 32'hF);
    check();
    tick();
    expect_v("fall_data", 0, 0, 32'hE);
    expect_v("fall_cap_early", 0, 3, 0);
    check();
    tick();
    expect_v("fall_cap1", 0, 3, 32'h1);
    expect_v("fall_cap2", 1, 3, 32'h1);
    expect_v("fall_irq_masked", 0, 4, 0);
    check();
    wr(2, 32'h1);
    expect_v("fall_irq1", 0, 4, 1);
    expect_v("fall_irq2", 1, 4, 1);
    check();
    wr(3, 32'h1);
    expect_v("w1c_cap", 0, 3, 0);
    expect_v("w1c_irq", 0, 4, 0);
    check();
    in_port = 4'hF;
    tick(DL + 1);
    expect_v("rise_cap1", 0, 3, 0);
    expect_v("rise_cap2", 1, 3, 32'h1);
    expect_v("rise_irq2", 1, 4, 1);
    check();
    wr(3, 32'hF);
`ifdef DE4_BUTTON_PIO_DEBOUNCE_EN
    in_port = 4'hD;
    tick(DC - 1);
    in_port = 4'hF;
    tick(DL + DC + 2);
    expect_v("glitch7_data", 0, 0, 32'hF);
    expect_v("glitch7_cap1", 0, 3, 0);
    expect_v("glitch7_cap2", 1, 3, 0);
    check();
    in_port = 4'hD;
    tick(DC);
    in_port = 4'hF;
    tick(DL + DC + 4);
`else
    in_port = 4'hD;
    tick(1);
    in_port = 4'hF;
    tick(DL + 3);
`endif
    expect_v("glitch_data", 0, 0, 32'hF);
    expect_v("glitch_cap1", 0, 3, 32'h2);
    expect_v("glitch_cap2", 1, 3, 32'h2);
    expect_v("glitch_irq1", 0, 4, 0);
    check();
    in_port = 4'hE;
    tick(DL + 2);
    expect_v("coll_cap3", 0, 3, 32'h3);
    check();
    wr(3, 32'h1);
    expect_v("coll_w1c", 0, 3, 32'h2);
    check();
    in_port = 4'hC;
    tick(DL);
    wr(3, 32'h2);
    expect_v("coll_setwins", 0, 3, 32'h2);
    check();
    tick();
    expect_v("coll_hold", 0, 3, 32'h2);
    check();
    wr(3, 32'h2);
    expect_v("coll_clear", 0, 3, 0);
    check();
    wr(3, 32'hF);
    wr(2, 32'h8);
    in_port = 4'h4;
    tick(DL);
    expect_v("any_fall_early", 1, 3, 0);
    check();
    tick();
    expect_v("any_fall_cap2", 1, 3, 32'h8);
    expect_v("any_fall_cap1", 0, 3, 32'h8);
    expect_v("any_fall_irq2", 1, 4, 1);
    expect_v("any_fall_irq1", 0, 4, 1);
    check();
    wr(3, 32'hF);
    expect_v("any_clr_irq2", 1, 4, 0);
    check();
    in_port = 4'hC;
    tick(DL + 1);
    expect_v("any_rise_cap2", 1, 3, 32'h8);
    expect_v("any_rise_cap1", 0, 3, 0);
    expect_v("any_rise_irq2", 1, 4, 1);
    expect_v("any_rise_irq1", 0, 4, 0);
    check();
    wr(2, 0);
    expect_v("any_mask_irq2", 1, 4, 0);
    expect_v("any_mask_cap2", 1, 3, 32'h8);
    check();
    in_port = 4'hF;
    tick(DL + 2);
    wr(3, 32'hF);
    in_port = 4'hB;
    tick(RST_AT);
    reset = 1;
    tick();
    reset = 0;
    expect_v("mrst_data", 0, 0, 32'hF);
    expect_v("mrst_cap1", 0, 3, 0);
    expect_v("mrst_cap2", 1, 3, 0);
    check();
    tick(DL - 1);
    expect_v("mrst_data_early", 0, 0, 32'hF);
    check();
    tick();
    expect_v("mrst_data_new", 0, 0, 32'hB);
    check();
    tick();
    expect_v("mrst_cap_new", 0, 3, 32'h4);
    check();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
